// File: rtl/timer_pkg.sv
// Shared types and limits for the programmable timer and its down-counter.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    RUNNING = 3'b010,
    DONE    = 3'b100
  } state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_t;

  localparam int TIMER_W_MIN = 2;

endpackage

// File: rtl/tmr_down_counter.sv
// W-bit loadable down-counter; saturates at zero and flags the step that reaches zero.
module tmr_down_counter
  import timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_next,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: load has priority over a decrement, zero never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero_next = (count_r == W'(1));
  assign count     = count_r;

endmodule

// File: rtl/prog_timer.sv
// Programmable one-shot/periodic timer with hold, abort and restart; RDY pulses on expiry.
module prog_timer
  import timer_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEF_MODE = 0
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         START,
  input  logic         STOP,
  input  logic         HOLD,
  input  logic         MODE,
  input  logic [W-1:0] LOAD,
  output logic         RDY,
  output logic         BUSY,
  output logic [W-1:0] COUNT
);

  // DEF_MODE documents the integrator's tie-off value for MODE; only its range is checked here.
  if ((W < TIMER_W_MIN) || (DEF_MODE < 0) || (DEF_MODE > 1)) begin : g_param_check
    $error("prog_timer: illegal W or DEF_MODE");
  end

  state_t       state_r, state_n;
  mode_t        mode_r, mode_n;
  logic [W-1:0] reload_r, reload_n;
  logic         cnt_load_s, cnt_en_s, zero_next_s;
  logic [W-1:0] cnt_val_s;

  tmr_down_counter #(.W(W)) u_cnt (
    .clk       (CLK),
    .rst_n     (N_RESET),
    .load      (cnt_load_s),
    .load_val  (cnt_val_s),
    .en        (cnt_en_s),
    .zero_next (zero_next_s),
    .count     (COUNT)
  );

  // State, reload value and mode registers.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_r  <= IDLE;
      mode_r   <= ONE_SHOT;
      reload_r <= '0;
    end else begin
      state_r  <= state_n;
      mode_r   <= mode_n;
      reload_r <= reload_n;
    end
  end

  // Next-state and counter control; STOP beats START beats HOLD beats decrement.
  always_comb begin
    state_n    = state_r;
    mode_n     = mode_r;
    reload_n   = reload_r;
    cnt_load_s = 1'b0;
    cnt_val_s  = '0;
    cnt_en_s   = 1'b0;
    if (STOP) begin
      state_n    = IDLE;
      cnt_load_s = 1'b1;
    end else if (START) begin
      reload_n   = LOAD;
      mode_n     = mode_t'(MODE);
      cnt_load_s = 1'b1;
      cnt_val_s  = LOAD;
      state_n    = (LOAD == '0) ? DONE : RUNNING;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = IDLE;
        end
        RUNNING: begin
          if (HOLD) begin
            state_n = RUNNING;
          end else begin
            cnt_en_s = 1'b1;
            state_n  = zero_next_s ? DONE : RUNNING;
          end
        end
        DONE: begin
          if (mode_r == ONE_SHOT) begin
            state_n = IDLE;
          end else if (reload_r != '0) begin
            cnt_load_s = 1'b1;
            cnt_val_s  = reload_r;
            state_n    = RUNNING;
          end else begin
            // Periodic with zero reload parks in DONE so RDY stays high.
            state_n = DONE;
          end
        end
        default: begin
          state_n    = IDLE;
          cnt_load_s = 1'b1;
        end
      endcase
    end
  end

  assign RDY  = (state_r == DONE);
  assign BUSY = (state_r == RUNNING);

endmodule

// File: tb/tb_prog_timer.sv
// Randomized and directed bench for prog_timer with a queue-based scoreboard and behavioural model.
module tb_prog_timer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         N_RESET, START, STOP, HOLD, MODE;
  logic [W-1:0] LOAD;
  logic         RDY, BUSY;
  logic [W-1:0] COUNT;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         rdy;
    logic         busy;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Model: phase 0 idle, 1 counting, 2 expired; rem is the remaining count.
  int m_phase, m_rem, m_reload;
  bit m_periodic;

  always #5 CLK = ~CLK;

  prog_timer #(.W(W), .DEF_MODE(0)) dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .START   (START),
    .STOP    (STOP),
    .HOLD    (HOLD),
    .MODE    (MODE),
    .LOAD    (LOAD),
    .RDY     (RDY),
    .BUSY    (BUSY),
    .COUNT   (COUNT)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_rem      = 0;
    m_reload   = 0;
    m_periodic = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit hd, input bit md, input int ld);
    if (sp) begin
      m_phase = 0;
      m_rem   = 0;
    end else if (st) begin
      m_reload   = ld;
      m_periodic = md;
      m_rem      = ld;
      m_phase    = (ld == 0) ? 2 : 1;
    end else if (m_phase == 1) begin
      if (!hd) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (!m_periodic) begin
        m_phase = 0;
      end else if (m_reload > 0) begin
        m_rem   = m_reload;
        m_phase = 1;
      end
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit hd, input bit md, input logic [W-1:0] ld);
    exp_t e;
    @(negedge CLK);
    START = st;
    STOP  = sp;
    HOLD  = hd;
    MODE  = md;
    LOAD  = ld;
    model_step(st, sp, hd, md, int'(ld));
    e.rdy  = (m_phase == 2);
    e.busy = (m_phase == 1);
    e.cnt  = W'(m_rem);
    exp_q.push_back(e);
    @(posedge CLK);
  endtask

  // Idle-input window; records first RDY cycle (edges after the last step) and pulse count.
  task automatic run(input int win, input int hold_from, input int hold_len,
                     output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= win; i++) begin
      step(1'b0, 1'b0, (i >= hold_from) && (i < hold_from + hold_len),
           ($urandom_range(0, 1) == 1), W'($urandom_range(0, 255)));
      #1;
      if (RDY) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  // Monitor: compare every registered output update against the model's expectation.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_rdy", int'(RDY), int'(e.rdy));
      chk("sb_busy", int'(BUSY), int'(e.busy));
      chk("sb_count", int'(COUNT), int'(e.cnt));
    end
  end

  initial begin
    int f, p;
    N_RESET = 1'b0;
    START = 1'b0; STOP = 1'b0; HOLD = 1'b0; MODE = 1'b0; LOAD = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_rdy", int'(RDY), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_count", int'(COUNT), 0);
    @(negedge CLK);
    N_RESET = 1'b1;

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    run(8, 0, 0, f, p);
    chk("oneshot5_latency", f, 5);
    chk("oneshot5_pulses", p, 1);

    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    run(16, 0, 0, f, p);
    chk("periodic3_first", f, 3);
    chk("periodic3_pulses", p, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    run(10, 0, 0, f, p);
    chk("periodic_stop_pulses", p, 0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    run(10, 4, 3, f, p);
    chk("hold_latency", f, 7);
    chk("hold_pulses", p, 1);

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd8);
    run(3, 0, 0, f, p);
    chk("restart_pre_pulses", p, 0);
    chk("restart_pre_count", int'(COUNT), 5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    run(6, 0, 0, f, p);
    chk("restart_latency", f, 2);
    chk("restart_pulses", p, 1);

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    #1;
    chk("load0_rdy", int'(RDY), 1);
    chk("load0_busy", int'(BUSY), 0);
    run(4, 0, 0, f, p);
    chk("load0_after_pulses", p, 0);

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    run(6, 0, 0, f, p);
    chk("start_stop_idle_pulses", p, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    run(8, 0, 0, f, p);
    chk("start_stop_run_pulses", p, 0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
    run(3, 0, 0, f, p);
    #2;
    N_RESET = 1'b0;
    #1;
    chk("async_rst_rdy", int'(RDY), 0);
    chk("async_rst_busy", int'(BUSY), 0);
    chk("async_rst_count", int'(COUNT), 0);
    model_reset();
    @(negedge CLK);
    N_RESET = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
    run(260, 0, 0, f, p);
    chk("max_load_latency", f, 255);
    chk("max_load_pulses", p, 1);

    repeat (3000) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6)));
    end

    @(posedge CLK);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
